multicycle_sequencer: RTL and testbench



---
 rtl/multicycle_sequencer_pkg.sv | 35 +++
 rtl/multicycle_sequencer.sv | 114 +++++++++++
 tb/tb_multicycle_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared state encoding and RISC-V base opcode constants for the multi-cycle sequencer.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_MEM    = 3'd4,
    SEQ_WB     = 3'd5,
    SEQ_HALT   = 3'd6
  } seq_state_e;

  localparam logic [6:0] OPCODE_LUI     = 7'h37;
  localparam logic [6:0] OPCODE_AUIPC   = 7'h17;
  localparam logic [6:0] OPCODE_JAL     = 7'h6F;
  localparam logic [6:0] OPCODE_JALR    = 7'h67;
  localparam logic [6:0] OPCODE_BRANCH  = 7'h63;
  localparam logic [6:0] OPCODE_LOAD    = 7'h03;
  localparam logic [6:0] OPCODE_STORE   = 7'h23;
  localparam logic [6:0] OPCODE_ARITH_I = 7'h13;
  localparam logic [6:0] OPCODE_ARITH_R = 7'h33;

  // Anything outside the nine supported opcodes traps the core into HALT.
  function automatic logic is_legal_op(input logic [6:0] op_f);
    logic legal;
    case (op_f)
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
      OPCODE_LOAD, OPCODE_STORE, OPCODE_ARITH_I, OPCODE_ARITH_R: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through FETCH..WB over
// one shared memory port and produces the phase-qualified datapath enables.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [6:0]           op,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  input  logic                 can_branch,
  input  logic                 should_jump,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_is_fetch,
  output logic                 ir_load,
  output logic                 mdr_load,
  output logic                 rf_write,
  output logic                 pc_write,
  output logic                 busy,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  seq_state_e           state_q, state_d;
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEQ_IDLE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    rf_write     = 1'b0;
    halted       = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (run) state_d = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = SEQ_DECODE;
        end
      end
      SEQ_DECODE: begin
        state_d = is_legal_op(op) ? SEQ_EXEC : SEQ_HALT;
      end
      SEQ_EXEC: begin
        // Branch wins over reg_write; a conditional branch never writes the RF.
        if (mem_read || mem_write) state_d = SEQ_MEM;
        else if (can_branch)       retire  = 1'b1;
        else if (reg_write)        state_d = SEQ_WB;
        else                       retire  = 1'b1;
      end
      SEQ_MEM: begin
        mem_req = 1'b1;
        mem_we  = mem_write;
        if (mem_ready) begin
          if (mem_write) begin
            retire = 1'b1;
          end else begin
            mdr_load = 1'b1;
            state_d  = SEQ_WB;
          end
        end
      end
      SEQ_WB: begin
        rf_write = 1'b1;
        retire   = 1'b1;
      end
      SEQ_HALT: begin
        halted = 1'b1;
      end
      default: state_d = SEQ_IDLE;
    endcase

    // run is only consulted here and in IDLE, so dropping it mid-instruction is harmless.
    if (retire) state_d = run ? SEQ_FETCH : SEQ_IDLE;
  end

  assign pc_write = retire;
  assign busy     = (state_q != SEQ_IDLE) && (state_q != SEQ_HALT);
  assign state    = state_q;
  assign instret  = instret_q;

  logic unused_ok;
  assign unused_ok = should_jump;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized scoreboard bench for multicycle_sequencer with a narrow-counter twin for wrap checks.
module tb_multicycle_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic run;
  logic [6:0] op;
  logic mem_read, mem_write, reg_write, can_branch, should_jump, mem_ready;
  logic mem_req, mem_we, mem_is_fetch, ir_load, mdr_load, rf_write, pc_write, busy, halted;
  logic [2:0]  state;
  logic [31:0] instret;
  logic s_mem_req, s_mem_we, s_mem_is_fetch, s_ir_load, s_mdr_load, s_rf_write, s_pc_write;
  logic s_busy, s_halted;
  logic [2:0] s_state;
  logic [2:0] s_instret;

  always #5 clk = ~clk;

  multicycle_sequencer #(.INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .can_branch(can_branch), .should_jump(should_jump), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
    .ir_load(ir_load), .mdr_load(mdr_load), .rf_write(rf_write), .pc_write(pc_write),
    .busy(busy), .halted(halted), .state(state), .instret(instret)
  );

  multicycle_sequencer #(.INSTRET_W(3)) dut_small (
    .clk(clk), .rst(rst), .run(run), .op(op),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .can_branch(can_branch), .should_jump(should_jump), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_is_fetch(s_mem_is_fetch),
    .ir_load(s_ir_load), .mdr_load(s_mdr_load), .rf_write(s_rf_write), .pc_write(s_pc_write),
    .busy(s_busy), .halted(s_halted), .state(s_state), .instret(s_instret)
  );

  typedef struct {
    int lat;
    int n_mdr;
    int n_rf;
    bit we;
    bit run_at_retire;
    int idx;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   fw    = 0;
  int   mw    = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Memory model: a request is granted after the configured number of wait cycles.
  initial begin
    bit in_req;
    int cnt;
    in_req = 1'b0;
    cnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_req = 1'b0;
        mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!in_req) begin
          cnt = mem_is_fetch ? fw : mw;
          in_req = 1'b1;
        end
        if (cnt == 0) begin
          mem_ready = 1'b1;
          in_req = 1'b0;
        end else begin
          mem_ready = 1'b0;
          cnt--;
        end
      end else begin
        in_req = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: times each instruction from FETCH entry and scores it at retire.
  initial begin
    bit in_instr, chk_next;
    int cyc, n_ir, n_mdr, n_rf, exp_next, exp_ret;
    bit saw_we;
    exp_t e;
    in_instr = 0; chk_next = 0; cyc = 0; n_ir = 0; n_mdr = 0; n_rf = 0;
    saw_we = 0; exp_next = 0; exp_ret = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en || rst) begin
        in_instr = 0;
        chk_next = 0;
      end else begin
        if (chk_next) begin
          chk("next_state", state, exp_next);
          chk("instret_after", instret, exp_ret);
          chk("instret_narrow", s_instret, exp_ret % 8);
          chk_next = 0;
        end
        if (!in_instr && state == 3'd1) begin
          in_instr = 1; cyc = 0; n_ir = 0; n_mdr = 0; n_rf = 0; saw_we = 0;
        end
        if (in_instr) begin
          cyc++;
          n_ir  += int'(ir_load);
          n_mdr += int'(mdr_load);
          n_rf  += int'(rf_write);
          if (mem_req && mem_we) saw_we = 1;
          if (pc_write) begin
            if (sb.size() == 0) begin
              chk("unexpected_retire", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("latency", cyc, e.lat);
              chk("ir_load_count", n_ir, 1);
              chk("mdr_load_count", n_mdr, e.n_mdr);
              chk("rf_write_count", n_rf, e.n_rf);
              chk("mem_we_seen", saw_we, e.we);
              chk("instret_before", instret, e.idx);
              exp_next = e.run_at_retire ? 1 : 0;
              exp_ret = e.idx + 1;
              chk_next = 1;
            end
            in_instr = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [9];
    int issued, k, t;
    bit drop, is_mem;
    exp_t e;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    rst = 1'b1; run = 1'b0; op = 7'h00;
    mem_read = 0; mem_write = 0; reg_write = 0; can_branch = 0; should_jump = 0;
    issued = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_instret", instret, 0);
    chk("rst_outputs", {mem_req, mem_we, mem_is_fetch, ir_load, mdr_load, rf_write,
                        pc_write, busy, halted}, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 8);
      op = ops[k];
      mem_read = 0; mem_write = 0; reg_write = 0; can_branch = 0; should_jump = 0;
      case (op)
        7'h63: begin can_branch = 1; reg_write = 1'($urandom_range(0, 1)); end
        7'h03: begin mem_read = 1; reg_write = 1; end
        7'h23: begin mem_write = 1; mem_read = 1'($urandom_range(0, 1)); end
        default: begin
          reg_write = ($urandom_range(0, 7) != 0);
          should_jump = (op == 7'h6F || op == 7'h67);
        end
      endcase
      fw = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      mw = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      drop = ($urandom_range(0, 5) == 0);

      // Reference: phase counts per instruction class with zero-wait memory, plus waits.
      is_mem = mem_read || mem_write;
      e.idx = issued;
      e.run_at_retire = !drop;
      e.we = is_mem && mem_write;
      e.n_mdr = (is_mem && !mem_write) ? 1 : 0;
      e.n_rf = ((is_mem && !mem_write) || (!is_mem && !can_branch && reg_write)) ? 1 : 0;
      if (is_mem)          e.lat = (mem_write ? 4 : 5) + fw + mw;
      else if (can_branch) e.lat = 3 + fw;
      else if (reg_write)  e.lat = 4 + fw;
      else                 e.lat = 3 + fw;
      sb.push_back(e);
      issued++;

      run = 1'b1;
      @(posedge clk);
      #1;
      if (drop) run = 1'b0;
      t = 0;
      do begin
        @(negedge clk);
        #2;
        t++;
      end while (!pc_write && t < 60);
      if (t >= 60) chk("retire_timeout", t, 0);
      @(posedge clk);
      #1;
      if (drop) repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;

    // Asynchronous reset while a fetch is stalled on memory.
    fw = 10;
    run = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (state != 3'd1 && t < 5);
    chk("reach_fetch", state, 1);
    chk("fetch_req", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_instret", instret, 0);
    chk("async_rst_narrow", s_instret, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_state", state, 0);

    // Illegal opcode traps into HALT and stays there with run still asserted.
    op = 7'h00;
    mem_read = 0; mem_write = 0; reg_write = 1; can_branch = 0;
    fw = 0;
    rst = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      #2;
      t++;
    end while (!halted && t < 10);
    chk("halt_reached", halted, 1);
    chk("halt_state", state, 6);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #2;
      chk("halt_quiet", {mem_req, mem_we, ir_load, mdr_load, rf_write, pc_write, busy}, 0);
      chk("halt_hold", {halted, state}, {1'b1, 3'd6});
    end
    chk("halt_instret", instret, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0t expected <2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
